// File: rtl/mp_mul_pkg.sv
// Shared definitions for the sequential multi-precision multiplier:
// FSM state encodings and the limb-counter width helper.
package mp_mul_pkg;

    typedef logic [1:0] state_t;

    // DRAIN is always encoded. It is only reachable when the core output
    // pipeline register is built in.
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Width of the limb index counters. Two limbs still need one bit.
    function automatic int cnt_width(input int limbs);
        return (limbs <= 2) ? 1 : $clog2(limbs);
    endfunction

endpackage

// File: rtl/karatsuba_core.sv
// Combinational N x N -> 2N unsigned multiplier using one Karatsuba split.
// The three half-width products are recombined modulo 2^(2N). The true
// product always fits in 2N bits, so the wrap-around in the middle term
// cancels out exactly.
module karatsuba_core #(
    parameter int N = 8
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] z
);

    generate
        if (N == 1) begin : g_bit
            // A single-bit product needs no split.
            assign z = {1'b0, x & y};
        end else begin : g_kara
            localparam int H  = N / 2;
            localparam int W2 = 2 * N;

            logic [H:0]    xs;
            logic [H:0]    ys;
            logic [W2-1:0] z0;
            logic [W2-1:0] z2;
            logic [W2-1:0] zm;
            logic [W2-1:0] z1;

            assign xs = {1'b0, x[H-1:0]} + {1'b0, x[N-1:H]};
            assign ys = {1'b0, y[H-1:0]} + {1'b0, y[N-1:H]};
            assign z0 = W2'(x[H-1:0]) * W2'(y[H-1:0]);
            assign z2 = W2'(x[N-1:H]) * W2'(y[N-1:H]);
            assign zm = W2'(xs) * W2'(ys);
            assign z1 = zm - z0 - z2;
            assign z  = (z2 << N) + (z1 << H) + z0;
        end
    endgenerate

endmodule

// File: rtl/mp_mul_limb_sel.sv
// Selects limb idx (bits [idx*N +: N]) out of a LIMBS*N-bit operand.
module mp_mul_limb_sel #(
    parameter int N     = 8,
    parameter int LIMBS = 4,
    parameter int CW    = 2
) (
    input  logic [LIMBS*N-1:0] vec,
    input  logic [CW-1:0]      idx,
    output logic [N-1:0]       limb
);

    // Build a plain one-hot compare mux over all limbs.
    always_comb begin
        limb = '0;
        for (int k = 0; k < LIMBS; k++) begin
            if (idx == CW'(k)) begin
                limb = vec[k*N +: N];
            end
        end
    end

endmodule

// File: rtl/mp_mul_seq.sv
// Sequential multi-precision unsigned multiplier, P = A*B.
// Each cycle one limb pair goes through the Karatsuba core, and the 2N-bit
// partial product is shifted by (i+j)*N and added into a 2W-bit accumulator.
// There are valid/ready handshakes on both sides, with one operation in flight.
// Define MP_MUL_CORE_REG_EN to register the core output, together with its
// shift amount, ahead of the accumulator. This adds one DRAIN cycle to the
// latency and does not change any result.
module mp_mul_seq
    import mp_mul_pkg::*;
#(
    parameter int N     = 8,
    parameter int LIMBS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LIMBS*N-1:0]     a,
    input  logic [LIMBS*N-1:0]     b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*LIMBS*N-1:0]   p,
    output logic                   busy
);

    localparam int W  = LIMBS * N;
    localparam int CW = cnt_width(LIMBS);
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   i_q, i_d;
    logic [CW-1:0]   j_q, j_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;

    logic [N-1:0]    limb_a;
    logic [N-1:0]    limb_b;
    logic [2*N-1:0]  core_out;
    logic [SW-1:0]   ij_sum;

    logic            add_en;
    logic [2*N-1:0]  add_val;
    logic [SW-1:0]   add_sh;
    logic [2*W-1:0]  term;

    mp_mul_limb_sel #(.N(N), .LIMBS(LIMBS), .CW(CW)) u_sel_a (
        .vec  (a_q),
        .idx  (i_q),
        .limb (limb_a)
    );

    mp_mul_limb_sel #(.N(N), .LIMBS(LIMBS), .CW(CW)) u_sel_b (
        .vec  (b_q),
        .idx  (j_q),
        .limb (limb_b)
    );

    karatsuba_core #(.N(N)) u_core (
        .x (limb_a),
        .y (limb_b),
        .z (core_out)
    );

    assign ij_sum = SW'(i_q) + SW'(j_q);

`ifdef MP_MUL_CORE_REG_EN
    logic [2*N-1:0]  pp_q, pp_d;
    logic [SW-1:0]   pp_sh_q, pp_sh_d;
    logic            pp_vld_q, pp_vld_d;

    // Capture the core product and its shift amount for every issued pair.
    always_comb begin
        pp_d     = core_out;
        pp_sh_d  = ij_sum;
        pp_vld_d = (state_q == ST_RUN);
    end

    // Pipeline register between the core and the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q     <= '0;
            pp_sh_q  <= '0;
            pp_vld_q <= 1'b0;
        end else begin
            pp_q     <= pp_d;
            pp_sh_q  <= pp_sh_d;
            pp_vld_q <= pp_vld_d;
        end
    end

    assign add_en  = pp_vld_q;
    assign add_val = pp_q;
    assign add_sh  = pp_sh_q;
`else
    assign add_en  = (state_q == ST_RUN);
    assign add_val = core_out;
    assign add_sh  = ij_sum;
`endif

    // Zero-extend the partial product and move it into limb position i+j.
    always_comb begin
        term = {{(2*W-2*N){1'b0}}, add_val} << (add_sh * N);
    end

    // Next-state logic for the FSM, the limb counters, the operands and the accumulator.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;

        if (add_en) begin
            acc_d = acc_q + term;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (j_q == LAST) begin
                    j_d = '0;
                    i_d = i_q + CW'(1);
                end else begin
                    j_d = j_q + CW'(1);
                end
                if (i_q == LAST && j_q == LAST) begin
                    i_d = '0;
`ifdef MP_MUL_CORE_REG_EN
                    state_d = ST_DRAIN;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset discards any operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign p         = acc_q;

endmodule

// File: doc/mp_mul_seq.md
Name: mp_mul_seq

Overview:
- Sequential multi-precision unsigned multiplier: P = A*B, where each operand is LIMBS limbs of N bits.
- Per cycle it feeds one limb pair into the team's combinational N-bit karatsuba core and shift-accumulates the 2N-bit partial product.
- Sits upstream and downstream of the core: stages operands into it and consumes its products.
- Valid/ready on both sides; one operation in flight.

Parameters:
- N, 8, limb width; power of 2; passed to the core.
- LIMBS, 4, limbs per operand; ≥2. Operand width W = LIMBS*N.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  W  multiplicand, unsigned.
- b  in  W  multiplier, unsigned.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- p  out  2W  product A*B.
- busy  out  1  high in RUN/DRAIN.

Behaviour:
- Reset (async, any state):
  - state=IDLE; i=j=0; acc=0.
  - p=0, out_valid=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded.
- Outputs:
  - in_ready = (state==IDLE), combinational from state.
  - busy = RUN or DRAIN.
  - p driven from acc register; stable while out_valid=1.
- IDLE:
  - on in_valid&&in_ready: capture a,b into op regs, acc=0, i=j=0, go RUN.
- RUN, each cycle:
  - core inputs = a_reg limb i, b_reg limb j (limb k = bits [k*N+N-1 : k*N]).
  - acc += core_out << ((i+j)*N).
  - j increments; at j==LIMBS-1, j wraps to 0 and i increments.
  - On the pair i=j=LIMBS-1: go DONE (or DRAIN with the optional feature).
- DONE:
  - out_valid=1.
  - on out_ready: go IDLE, out_valid=0.
  - in_valid ignored (in_ready=0).
  - Held indefinitely under out_ready=0.
- Latency:
  - acceptance edge E0; out_valid rises at edge E0+LIMBS² (16 for defaults).
  - Throughput: one operation per LIMBS²+2 cycles minimum (DONE→IDLE→accept).
- Arithmetic:
  - acc is 2W bits; no overflow possible, since partial sums ≤ final product < 2^(2W).
  - Shifted terms are zero-extended.
  - Operand zero is not short-cut; the full schedule always runs.
- Simultaneous events:
  - out_ready with in_valid in DONE: the product handshake completes; the new operand is accepted no earlier than the next cycle, in IDLE.
  - in_valid during RUN: ignored, no capture.
- Counters: i,j are $clog2(LIMBS) bits, or 1 bit when LIMBS=2; never reach LIMBS.

Optional Feature:
- Macro MP_MUL_CORE_REG_EN.
- Defined:
  - core_out is registered together with its shift amount (i+j) and a valid bit; the accumulate uses the registered values.
  - After the last pair issues, state DRAIN lasts one cycle to retire the final registered product, then DONE.
  - Latency becomes LIMBS²+1.
  - Reset clears the pipeline register and its valid bit.
- Undefined:
  - No DRAIN state, latency LIMBS².
  - Results are identical either way.

Decomposition:
- Package mp_mul_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE} (DRAIN encoded always, reachable only with the macro).
  - Width helper function for the counter width.
- Sub-module: existing karatsuba core, instantiated once with N.
- Optional thin sub-module mp_mul_limb_sel (limb mux by index); otherwise inline.

Test Plan (N=8, LIMBS=4 unless noted):
- Max operands: a=0xFFFFFFFF, b=0xFFFFFFFF → p=0xFFFFFFFE00000001; out_valid exactly 16 cycles after accept (17 with MP_MUL_CORE_REG_EN).
- Sparse operands: a=0x00010002, b=0x00030004 → p=0x00000003000A0008. Zero operands: a=0, b=0xDEADBEEF → p=0 after the full 16 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → p and out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → out_valid drops the next cycle, in_ready=1.
- Reset mid-RUN (rst asserted 7 cycles after accept, async, mid-cycle) → out_valid=0, p=0, in_ready=1 immediately; next op a=3, b=5 → p=15.
- Back-to-back: in_valid held high, out_ready tied high, 200 random pairs → every p matches the a*b model, no operand lost or duplicated. Repeat with LIMBS=2, N=4.
